// File: rtl/pcs_synchronizer.sv
// Code-group synchronization FSM for a 1000BASE-X style PCS receive path.
// Registers the incoming group, then tracks comma alignment and bad-group history.
module pcs_synchronizer #(
    parameter logic [9:0] COMMA_NEG = 10'b0011111010,
    parameter logic [9:0] COMMA_POS = 10'b1100000101
) (
    input  logic       sync_clk,
    input  logic       mr_main_reset,
    input  logic [9:0] rx_code_group,
    input  logic       existence,
    output logic [9:0] code_group,
    output logic       sync_status,
    output logic       rx_even,
    output logic [3:0] sync_state
);

    typedef enum logic [3:0] {
        StLossOfSync     = 4'd0,
        StCommaDetect1   = 4'd1,
        StAcquireSync1   = 4'd2,
        StCommaDetect2   = 4'd3,
        StAcquireSync2   = 4'd4,
        StCommaDetect3   = 4'd5,
        StSyncAcquired1  = 4'd6,
        StSyncAcquired2  = 4'd7,
        StSyncAcquired2a = 4'd8,
        StSyncAcquired3  = 4'd9,
        StSyncAcquired3a = 4'd10,
        StSyncAcquired4  = 4'd11,
        StSyncAcquired4a = 4'd12
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] good_cgs_q, good_cgs_d;

    logic comma, aligned_comma, cgbad, data;
    logic next_comma_detect, next_sync_acquired;

    assign comma         = (code_group == COMMA_NEG) || (code_group == COMMA_POS);
    assign aligned_comma = comma && !rx_even;
    assign cgbad         = !existence || (comma && rx_even);
    assign data          = existence && !comma;

    always_comb begin
        state_d    = state_q;
        good_cgs_d = good_cgs_q;
        case (state_q)
            StLossOfSync:   if (comma) state_d = StCommaDetect1;
            StCommaDetect1: state_d = data ? StAcquireSync1 : StLossOfSync;
            StCommaDetect2: state_d = data ? StAcquireSync2 : StLossOfSync;
            StCommaDetect3: state_d = data ? StSyncAcquired1 : StLossOfSync;
            StAcquireSync1: begin
                if (cgbad) state_d = StLossOfSync;
                else if (aligned_comma) state_d = StCommaDetect2;
            end
            StAcquireSync2: begin
                if (cgbad) state_d = StLossOfSync;
                else if (aligned_comma) state_d = StCommaDetect3;
            end
            StSyncAcquired1: if (cgbad) state_d = StSyncAcquired2;
            StSyncAcquired2: begin
                if (cgbad) begin
                    good_cgs_d = 2'd0;
                    state_d    = StSyncAcquired3;
                end else begin
                    good_cgs_d = 2'd1;
                    state_d    = StSyncAcquired2a;
                end
            end
            StSyncAcquired3: begin
                if (cgbad) begin
                    good_cgs_d = 2'd0;
                    state_d    = StSyncAcquired4;
                end else begin
                    good_cgs_d = 2'd1;
                    state_d    = StSyncAcquired3a;
                end
            end
            StSyncAcquired4: begin
                if (cgbad) begin
                    state_d = StLossOfSync;
                end else begin
                    good_cgs_d = 2'd1;
                    state_d    = StSyncAcquired4a;
                end
            end
            StSyncAcquired2a: begin
                if (cgbad) state_d = StSyncAcquired3;
                else if (good_cgs_q == 2'd3) state_d = StSyncAcquired1;
                else good_cgs_d = good_cgs_q + 2'd1;
            end
            StSyncAcquired3a: begin
                if (cgbad) state_d = StSyncAcquired4;
                else if (good_cgs_q == 2'd3) state_d = StSyncAcquired2;
                else good_cgs_d = good_cgs_q + 2'd1;
            end
            StSyncAcquired4a: begin
                if (cgbad) state_d = StLossOfSync;
                else if (good_cgs_q == 2'd3) state_d = StSyncAcquired3;
                else good_cgs_d = good_cgs_q + 2'd1;
            end
            default: state_d = StLossOfSync;
        endcase
    end

    // rx_even and sync_status are registered from the next state so they line up with it
    assign next_comma_detect  = (state_d == StCommaDetect1) || (state_d == StCommaDetect2) ||
                                (state_d == StCommaDetect3);
    assign next_sync_acquired = (state_d == StSyncAcquired1)  || (state_d == StSyncAcquired2)  ||
                                (state_d == StSyncAcquired2a) || (state_d == StSyncAcquired3)  ||
                                (state_d == StSyncAcquired3a) || (state_d == StSyncAcquired4)  ||
                                (state_d == StSyncAcquired4a);

    always_ff @(posedge sync_clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q     <= StLossOfSync;
            good_cgs_q  <= 2'd0;
            code_group  <= 10'd0;
            rx_even     <= 1'b0;
            sync_status <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cgs_q  <= good_cgs_d;
            code_group  <= rx_code_group;
            rx_even     <= next_comma_detect ? 1'b1 : ~rx_even;
            sync_status <= next_sync_acquired;
        end
    end

    assign sync_state = state_q;

endmodule

// File: tb/tb_pcs_synchronizer.sv
// Randomized bench for pcs_synchronizer: behavioural reference compared every cycle,
// plus directed acquisition / loss scenarios with literal expectations.
module tb_pcs_synchronizer;

    localparam logic [9:0] K_NEG   = 10'b0011111010;
    localparam logic [9:0] K_POS   = 10'b1100000101;
    localparam logic [9:0] D_A     = 10'b1001110100;
    localparam logic [9:0] D_B     = 10'b0110001011;
    localparam logic [9:0] BAD_CG  = 10'b0000000011;

    logic       sync_clk = 1'b0;
    logic       mr_main_reset = 1'b1;
    logic [9:0] rx_code_group = 10'd0;
    logic       existence;
    logic [9:0] code_group;
    logic       sync_status;
    logic       rx_even;
    logic [3:0] sync_state;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    pcs_synchronizer #(
        .COMMA_NEG(K_NEG),
        .COMMA_POS(K_POS)
    ) dut (
        .sync_clk     (sync_clk),
        .mr_main_reset(mr_main_reset),
        .rx_code_group(rx_code_group),
        .existence    (existence),
        .code_group   (code_group),
        .sync_status  (sync_status),
        .rx_even      (rx_even),
        .sync_state   (sync_state)
    );

    always #5 sync_clk = ~sync_clk;

    // Stand-in ROM: a group is valid when its disparity is within +/-2
    assign existence = ($countones(code_group) >= 4) && ($countones(code_group) <= 6);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state numbered 0..12; comma-detect = 1,3,5; acquire = 2,4;
    // sync base states 6,7,9,11; "A" states 8,10,12.
    typedef struct packed {
        logic [3:0] st;
        logic [1:0] gc;
        logic       ev;
    } mstate_t;

    function automatic mstate_t model_next(input mstate_t m, input logic [9:0] cg);
        mstate_t r;
        int  s, n, ones;
        bit  exist, comma, bad, dat;
        ones  = $countones(cg);
        exist = (ones >= 4) && (ones <= 6);
        comma = (cg == K_NEG) || (cg == K_POS);
        bad   = !exist || (comma && m.ev);
        dat   = exist && !comma;
        s = int'(m.st);
        n = s;
        r = m;
        if (s == 0) begin
            n = comma ? 1 : 0;
        end else if (s == 1 || s == 3 || s == 5) begin
            n = dat ? s + 1 : 0;
        end else if (s == 2 || s == 4) begin
            if (bad) n = 0;
            else if (comma && !m.ev) n = s + 1;
        end else if (s == 6) begin
            n = bad ? 7 : 6;
        end else if (s == 7 || s == 9 || s == 11) begin
            if (bad) begin
                r.gc = 2'd0;
                n = (s == 11) ? 0 : s + 2;
            end else begin
                r.gc = 2'd1;
                n = s + 1;
            end
        end else begin
            if (bad) n = (s == 12) ? 0 : s + 1;
            else if (m.gc == 2'd3) n = (s == 8) ? 6 : s - 3;
            else r.gc = m.gc + 2'd1;
        end
        r.st = 4'(n);
        r.ev = (n == 1 || n == 3 || n == 5) ? 1'b1 : !m.ev;
        return r;
    endfunction

    mstate_t    m;
    logic [9:0] m_cg;

    always @(posedge sync_clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            m    <= '0;
            m_cg <= 10'd0;
        end else begin
            m    <= model_next(m, m_cg);
            m_cg <= rx_code_group;
        end
    end

    always @(negedge sync_clk) begin
        if (check_en) begin
            check("model_state", int'(sync_state), int'(m.st));
            check("model_status", int'(sync_status), (m.st >= 4'd6) ? 1 : 0);
            check("model_rx_even", int'(rx_even), int'(m.ev));
            check("model_code_group", int'(code_group), int'(m_cg));
        end
    end

    task automatic step(input logic [9:0] g);
        @(negedge sync_clk);
        rx_code_group = g;
        @(posedge sync_clk);
        #1;
    endtask

    task automatic expect_st(input string name, input int st, input int status);
        check({name, "_state"}, int'(sync_state), st);
        check({name, "_status"}, int'(sync_status), status);
    endtask

    task automatic do_reset();
        @(negedge sync_clk);
        #2 mr_main_reset = 1'b0;
        #1;
        check("reset_state", int'(sync_state), 0);
        check("reset_status", int'(sync_status), 0);
        check("reset_code_group", int'(code_group), 0);
        check("reset_rx_even", int'(rx_even), 0);
        @(negedge sync_clk);
        #2 mr_main_reset = 1'b1;
    endtask

    task automatic acquire(input bit chk);
        step(K_NEG);
        step(D_A);
        if (chk) expect_st("acq1", 1, 0);
        step(K_POS);
        if (chk) expect_st("acq2", 2, 0);
        step(D_B);
        if (chk) expect_st("acq3", 3, 0);
        step(K_NEG);
        if (chk) expect_st("acq4", 4, 0);
        step(D_A);
        if (chk) expect_st("acq5", 5, 0);
        step(D_B);
        if (chk) expect_st("acq6", 6, 1);
    endtask

    logic [9:0] data_words [4] = '{10'b1001110100, 10'b0110001011,
                                   10'b1011010100, 10'b0100101011};

    initial begin
        logic [9:0] g;
        int r;
        bit even_pos;
        #1 mr_main_reset = 1'b0;
        @(negedge sync_clk);
        check_en = 1'b1;
        check("init_state", int'(sync_state), 0);
        check("init_code_group", int'(code_group), 0);
        #2 mr_main_reset = 1'b1;

        // Full acquisition, then one bad followed by good groups
        acquire(1'b1);
        check("model_pin_sync", int'(m.st), 6);
        step(BAD_CG);
        expect_st("sa1_hold", 6, 1);
        step(D_A);
        expect_st("recov1", 7, 1);
        step(D_B);
        expect_st("recov2", 8, 1);
        step(D_A);
        expect_st("recov3", 8, 1);
        step(D_B);
        expect_st("recov4", 8, 1);
        step(D_A);
        expect_st("recov5", 6, 1);

        // Async reset while synchronized
        do_reset();

        // Four consecutive bad groups lose sync
        acquire(1'b0);
        expect_st("reacq", 6, 1);
        step(BAD_CG);
        step(BAD_CG);
        expect_st("loss1", 7, 1);
        step(BAD_CG);
        expect_st("loss2", 9, 1);
        step(BAD_CG);
        expect_st("loss3", 11, 1);
        step(D_A);
        expect_st("loss4", 0, 0);

        // Invalid group right after a comma
        do_reset();
        step(K_POS);
        step(BAD_CG);
        expect_st("cd1_comma", 1, 0);
        step(D_A);
        expect_st("cd1_invalid", 0, 0);

        // Comma on an odd position during ACQUIRE_SYNC_1
        do_reset();
        step(K_NEG);
        step(D_A);
        expect_st("odd1", 1, 0);
        step(D_B);
        expect_st("odd2", 2, 0);
        step(K_POS);
        expect_st("odd3", 2, 0);
        step(D_A);
        expect_st("odd4", 0, 0);

        // Random stream: commas mostly on even positions, some errors injected
        do_reset();
        even_pos = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) g = 10'($urandom_range(0, 7));
            else if (r < 8) g = $urandom_range(0, 1) ? K_POS : K_NEG;
            else if (r < 14) g = 10'($urandom);
            else if (even_pos && r < 60) g = $urandom_range(0, 1) ? K_POS : K_NEG;
            else g = data_words[$urandom_range(0, 3)];
            step(g);
            even_pos = !even_pos;
            if ($urandom_range(0, 799) == 0) do_reset();
        end

        step(D_A);
        step(D_A);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcs_synchronizer.md
PCS_SYNCHRONIZER -- requirements
Module: pcs_synchronizer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter COMMA_NEG, default 10'b0011111010, SHALL be the K28.5 code group for running disparity minus.
REQ-003 Parameter COMMA_POS, default 10'b1100000101, SHALL be the K28.5 code group for running disparity plus.
REQ-004 sync_clk  in  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-005 mr_main_reset  in  1  SHALL be the asynchronous active-low reset.
REQ-006 rx_code_group  in  10  SHALL carry the received 10-bit code group, one per clock.
REQ-007 existence  in  1  SHALL be the validity flag from the external code-group ROM, combinationally derived from code_group; 1 means valid.
REQ-008 code_group  out  10  SHALL be rx_code_group registered by one clock, and feeds the ROM.
REQ-009 sync_status  out  1  SHALL be 1 when synchronization is acquired.
REQ-010 rx_even  out  1  SHALL be the even/odd parity flag of the last evaluated code group.
REQ-011 sync_state  out  4  SHALL be the current FSM state encoding, 0..12, in the order of REQ-016.

Function
REQ-012 Each clock, the FSM SHALL evaluate code_group and existence together; the state therefore reflects a group two clocks after it appears on rx_code_group.
REQ-013 comma SHALL be true when code_group equals COMMA_NEG or COMMA_POS.
REQ-014 An aligned comma is comma with rx_even==0; cgbad SHALL be !existence OR (comma AND rx_even==1); cggood SHALL be !cgbad; data SHALL be existence AND !comma.
REQ-015 rx_even SHALL be set to 1 when the next state is any COMMA_DETECT state; otherwise it SHALL toggle every clock.
REQ-016 The states SHALL be LOSS_OF_SYNC(0), COMMA_DETECT_1(1), ACQUIRE_SYNC_1(2), COMMA_DETECT_2(3), ACQUIRE_SYNC_2(4), COMMA_DETECT_3(5), SYNC_ACQUIRED_1(6), SYNC_ACQUIRED_2(7), SYNC_ACQUIRED_2A(8), SYNC_ACQUIRED_3(9), SYNC_ACQUIRED_3A(10), SYNC_ACQUIRED_4(11) and SYNC_ACQUIRED_4A(12).
REQ-017 LOSS_OF_SYNC SHALL go to COMMA_DETECT_1 on comma of either parity, and stay otherwise.
REQ-018 COMMA_DETECT_n (n=1,2,3) SHALL go to ACQUIRE_SYNC_1, ACQUIRE_SYNC_2 and SYNC_ACQUIRED_1 respectively on data, and to LOSS_OF_SYNC otherwise.
REQ-019 ACQUIRE_SYNC_n SHALL go to LOSS_OF_SYNC on cgbad and to COMMA_DETECT_(n+1) on an aligned comma, and stay otherwise.
REQ-020 SYNC_ACQUIRED_1 SHALL go to SYNC_ACQUIRED_2 on cgbad, and stay otherwise.
REQ-021 SYNC_ACQUIRED_k (k=2,3) SHALL clear good_cgs and go to SYNC_ACQUIRED_(k+1) on cgbad; on cggood it SHALL go to SYNC_ACQUIRED_kA with good_cgs=1.
REQ-022 SYNC_ACQUIRED_4 SHALL go to LOSS_OF_SYNC on cgbad; on cggood it SHALL go to SYNC_ACQUIRED_4A with good_cgs=1.
REQ-023 SYNC_ACQUIRED_kA, on cgbad, SHALL go to SYNC_ACQUIRED_(k+1), or to LOSS_OF_SYNC when k=4.
REQ-024 SYNC_ACQUIRED_kA, on cggood with good_cgs==3, SHALL go to SYNC_ACQUIRED_(k-1), where 2A returns to SYNC_ACQUIRED_1; on other cggood it SHALL increment good_cgs and stay.
REQ-025 good_cgs SHALL be a 2-bit counter that never wraps; it is used only as defined in REQ-021 to REQ-024.
REQ-026 sync_status SHALL be a registered 1 in all SYNC_ACQUIRED* states and 0 in all other states.

Reset
REQ-027 While mr_main_reset==0, the outputs SHALL be held at: state LOSS_OF_SYNC, code_group=0, rx_even=0, sync_status=0, good_cgs=0.
REQ-028 Asserting reset mid-operation SHALL take effect immediately, without waiting for a clock edge.
REQ-029 After release, the block SHALL resume on the first rising edge.

Verification
REQ-030 Reset pulse low while in SYNC_ACQUIRED_1: immediately sync_state=0, sync_status=0 and code_group=0.
REQ-031 Stream of K28.5 followed by valid D-groups, alternating comma/data ×3: expect states 1,2,3,4,5,6; sync_status=1 after the third comma's following data group.
REQ-032 Invalid group (existence=0) in COMMA_DETECT_1 -> LOSS_OF_SYNC.
REQ-033 Comma on an odd position during ACQUIRE_SYNC_1 -> LOSS_OF_SYNC.
REQ-034 In SYNC_ACQUIRED_1: one bad group then 4 good -> sequence 7, 8, 8, 8, 6; sync_status stays 1.
REQ-035 In SYNC_ACQUIRED_1: 4 consecutive bad groups -> 7, 9, 11, 0; sync_status drops to 0 on entry to state 0.
